// File: rtl/sdram_rd_stream.sv
// Streams one frame from the SDRAM read FIFO as a pixel stream with SOF/EOL
// markers. A 2-entry skid buffer absorbs the one-cycle FIFO read latency.
module sdram_rd_stream #(
  parameter int H_PIX   = 640,
  parameter int V_LINES = 480,
  parameter int RST_CYC = 8,
  parameter int PREFILL = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        frame_start,
  input  logic [9:0]  rd_fifo_num,
  input  logic [15:0] rd_fifo_rd_data,
  output logic        rd_fifo_rd_req,
  output logic        rd_rst,
  output logic        read_valid,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        frame_err
);

  localparam int TOTAL = H_PIX * V_LINES;
  localparam int PW = $clog2(TOTAL + 1);
  localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] STREAM = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] rst_cnt;
  logic [PW-1:0] pop_cnt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [1:0]    occ;
  logic          inflight;
  logic [15:0]   buf0, buf1;

  logic accept, last_beat, restart, drop, clear;

  assign accept    = m_valid && m_ready;
  assign last_beat = accept && (x_cnt == XW'(H_PIX - 1)) && (y_cnt == YW'(V_LINES - 1));
  assign restart   = init_end && frame_start;
  assign drop      = !init_end && (state != IDLE);
  assign clear     = drop || restart || ((state == STREAM) && last_beat);

  // No pop on a cycle that aborts the frame, so the FIFO never loses a word
  // the restarted frame would need.
  assign rd_fifo_rd_req = (state == STREAM) && !sys_rst && init_end && !frame_start &&
                          (({1'b0, occ} + {2'b0, inflight}) < 3'd2) &&
                          (rd_fifo_num > {9'b0, inflight}) &&
                          (pop_cnt < PW'(TOTAL));

  assign rd_rst     = (state == FLUSH);
  assign read_valid = (state == FILL) || (state == STREAM);
  assign m_valid    = (occ != 2'd0);
  assign m_data     = m_valid ? buf0 : 16'd0;
  assign m_sof      = m_valid && (x_cnt == '0) && (y_cnt == '0);
  assign m_eol      = m_valid && (x_cnt == XW'(H_PIX - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      pop_cnt   <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      buf0      <= 16'd0;
      buf1      <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= restart && (state != IDLE);
      if (clear) begin
        // Dropping inflight discards data from a read already issued.
        state    <= restart ? FLUSH : IDLE;
        rst_cnt  <= '0;
        pop_cnt  <= '0;
        x_cnt    <= '0;
        y_cnt    <= '0;
        occ      <= 2'd0;
        inflight <= 1'b0;
      end else begin
        inflight <= rd_fifo_rd_req;
        if (rd_fifo_rd_req) pop_cnt <= pop_cnt + 1'b1;

        if (inflight && !accept) begin
          if (occ == 2'd0) buf0 <= rd_fifo_rd_data;
          else             buf1 <= rd_fifo_rd_data;
          occ <= occ + 2'd1;
        end else if (!inflight && accept) begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end else if (inflight && accept) begin
          if (occ == 2'd1) buf0 <= rd_fifo_rd_data;
          else begin
            buf0 <= buf1;
            buf1 <= rd_fifo_rd_data;
          end
        end

        if (accept) begin
          if (x_cnt == XW'(H_PIX - 1)) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == YW'(V_LINES - 1)) ? '0 : y_cnt + 1'b1;
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end

        case (state)
          FLUSH:   if (rst_cnt == RW'(RST_CYC - 1)) state <= FILL;
                   else rst_cnt <= rst_cnt + 1'b1;
          FILL:    if (rd_fifo_num >= 10'(PREFILL)) state <= STREAM;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_rd_stream.sv
// Randomized bench for sdram_rd_stream: queue-based FIFO/SDRAM source, a
// phase-level reference model checked every cycle, plus directed scenarios.
module tb_sdram_rd_stream;
  localparam int H = 4, V = 2, RC = 8, PF = 16, TOT = H * V;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  rd_fifo_num = '0;
  logic [15:0] rd_fifo_rd_data = '0;
  logic        rd_fifo_rd_req, rd_rst, read_valid, m_valid, m_sof, m_eol, frame_err;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;

  always #5 sys_clk = ~sys_clk;

  sdram_rd_stream #(.H_PIX(H), .V_LINES(V), .RST_CYC(RC), .PREFILL(PF)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .frame_start(frame_start),
    .rd_fifo_num(rd_fifo_num), .rd_fifo_rd_data(rd_fifo_rd_data),
    .rd_fifo_rd_req(rd_fifo_rd_req), .rd_rst(rd_rst), .read_valid(read_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .m_eol(m_eol), .frame_err(frame_err));

  int n_chk = 0, n_pass = 0;

  // bench drive state
  logic rst_v = 1'b1, init_v = 1'b1;
  int   rdy_mode = 0, pat_i = 0, cap = 32;

  // FIFO / SDRAM source
  logic [15:0] q[$];
  int          next_word = 1;
  logic        pend_v = 1'b0;
  logic [15:0] pend_d = '0;

  // reference model: phase 0 idle, 1 flush, 2 fill, 3 stream
  int ph = 0, fcnt = 0, avail = 0, infl = 0, acc = 0, pops = 0, frames_done = 0;
  int err_exp = 0;

  // literal capture
  int          rst_seen = 0, pops_b = 0;
  logic [15:0] got[$], eols[$], sofs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_clear();
    avail = 0; infl = 0; acc = 0; pops = 0;
  endtask

  task automatic check_cycle();
    chk("rd_rst", int'(rd_rst), int'(ph == 1));
    chk("read_valid", int'(read_valid), int'(ph >= 2));
    chk("m_valid", int'(m_valid), int'(avail > 0));
    chk("frame_err", int'(frame_err), err_exp);
    if (m_valid) begin
      chk("m_data", int'(m_data), acc + 1);
      chk("m_sof", int'(m_sof), int'(acc == 0));
      chk("m_eol", int'(m_eol), int'(acc % H == H - 1));
    end else begin
      chk("m_sof_idle", int'(m_sof), 0);
      chk("m_eol_idle", int'(m_eol), 0);
    end
    if (rd_fifo_rd_req)
      chk("rd_req_legal", int'(ph == 3 && avail + infl < 2 && int'(rd_fifo_num) > infl && pops < TOT), 1);
    if (rd_rst) rst_seen++;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      if (m_eol) eols.push_back(m_data);
      if (m_sof) sofs.push_back(m_data);
    end
  endtask

  task automatic model_update(input logic fs_i);
    int a;
    err_exp = 0;
    if (rst_v) begin
      model_clear(); ph = 0;
    end else if (ph != 0 && !init_v) begin
      model_clear(); ph = 0;
    end else if (fs_i && init_v) begin
      err_exp = int'(ph != 0);
      model_clear(); ph = 1; fcnt = 0;
    end else begin
      case (ph)
        1: begin fcnt++; if (fcnt == RC) ph = 2; end
        2: if (int'(rd_fifo_num) >= PF) ph = 3;
        3: begin
          a = int'(avail > 0 && m_ready);
          avail = avail + infl - a;
          infl = int'(rd_fifo_rd_req);
          if (rd_fifo_rd_req) pops++;
          if (a != 0) acc++;
          if (acc == TOT) begin
            chk("frame_pops", pops, TOT);
            frames_done++;
            model_clear(); ph = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic fs_i);
    @(negedge sys_clk);
    sys_rst = rst_v; init_end = init_v; frame_start = fs_i;
    rd_fifo_rd_data = pend_v ? pend_d : 16'($urandom);
    pend_v = 1'b0;
    if (rd_rst) begin
      q.delete(); next_word = 1;
    end else if (read_valid && q.size() < cap && $urandom_range(0, 3) != 0) begin
      q.push_back(16'(next_word)); next_word++;
    end
    rd_fifo_num = 10'(q.size());
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: begin m_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    #2;
    check_cycle();
    if (rd_fifo_rd_req) begin
      pops_b++;
      if (q.size() == 0) chk("pop_from_empty", 1, 0);
      else begin pend_d = q.pop_front(); pend_v = 1'b1; end
    end
    model_update(fs_i);
  endtask

  task automatic run_idle(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      step(1'b0);
      if (ph == 0) break;
    end
    if (i == max_cyc) chk("timeout_frame", 0, 1);
  endtask

  task automatic wait_stream(input int beats);
    int i;
    for (i = 0; i < 300; i++) begin
      if (ph == 3 && acc >= beats) break;
      step(1'b0);
    end
    if (i == 300) chk("timeout_stream", 0, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd_req"}, int'(rd_fifo_rd_req), 0);
    chk({nm, "_rd_rst"}, int'(rd_rst), 0);
    chk({nm, "_read_valid"}, int'(read_valid), 0);
    chk({nm, "_m_valid"}, int'(m_valid), 0);
    chk({nm, "_m_data"}, int'(m_data), 0);
    chk({nm, "_m_sof"}, int'(m_sof), 0);
    chk({nm, "_m_eol"}, int'(m_eol), 0);
    chk({nm, "_frame_err"}, int'(frame_err), 0);
  endtask

  task automatic clean_frame(input string nm);
    rst_seen = 0; pops_b = 0; got.delete(); eols.delete(); sofs.delete();
    step(1'b1);
    run_idle(300);
    chk({nm, "_rst_len"}, rst_seen, RC);
    chk({nm, "_beats"}, got.size(), TOT);
    for (int i = 0; i < TOT; i++)
      chk({nm, "_data"}, (i < got.size()) ? int'(got[i]) : -1, i + 1);
    chk({nm, "_sof_cnt"}, sofs.size(), 1);
    chk({nm, "_sof_data"}, (sofs.size() > 0) ? int'(sofs[0]) : -1, 1);
    chk({nm, "_eol_cnt"}, eols.size(), 2);
    chk({nm, "_eol0"}, (eols.size() > 0) ? int'(eols[0]) : -1, 4);
    chk({nm, "_eol1"}, (eols.size() > 1) ? int'(eols[1]) : -1, 8);
    chk({nm, "_pops"}, pops_b, TOT);
    step(1'b0);
    chk({nm, "_idle_rv"}, int'(read_valid), 0);
  endtask

  initial begin
    int i;
    repeat (3) step(1'b0);
    chk_all_zero("reset");
    rst_v = 1'b0;
    repeat (2) step(1'b0);

    // full-rate frame, then a 1,0,0,1 stalled frame
    rdy_mode = 0; clean_frame("f_ready");
    rdy_mode = 1; pat_i = 0; clean_frame("f_stall");

    // FILL must hold while the FIFO sits one word short of PREFILL
    rdy_mode = 0; cap = PF - 1;
    step(1'b1);
    for (i = 0; i < 200 && !(ph == 2 && int'(rd_fifo_num) == PF - 1); i++) step(1'b0);
    if (i == 200) chk("timeout_fill", 0, 1);
    repeat (10) step(1'b0);
    chk("fill_read_valid", int'(read_valid), 1);
    chk("fill_m_valid", int'(m_valid), 0);
    chk("fill_no_pop", int'(rd_fifo_rd_req), 0);
    cap = 32;
    for (i = 0; i < 100 && int'(rd_fifo_num) < PF; i++) step(1'b0);
    step(1'b0);
    chk("fill_to_stream_pop", int'(rd_fifo_rd_req), 1);
    chk("fill_to_stream_rv", int'(read_valid), 1);
    run_idle(300);

    // abort after 3 accepted beats and restart
    rdy_mode = 2;
    step(1'b1);
    wait_stream(3);
    step(1'b1);
    sofs.delete();
    step(1'b0);
    chk("abort_frame_err", int'(frame_err), 1);
    chk("abort_m_valid", int'(m_valid), 0);
    chk("abort_rd_rst", int'(rd_rst), 1);
    run_idle(300);
    chk("restart_sof", (sofs.size() > 0) ? int'(sofs[0]) : -1, 1);

    // frame_start ignored before SDRAM init
    init_v = 1'b0; rst_seen = 0;
    step(1'b1);
    repeat (12) step(1'b0);
    chk("noinit_rd_rst", rst_seen, 0);
    chk("noinit_rv", int'(read_valid), 0);
    init_v = 1'b1;

    // init_end loss mid-stream: silent return to idle
    step(1'b1);
    wait_stream(2);
    init_v = 1'b0;
    step(1'b0); step(1'b0);
    chk("initdrop_rv", int'(read_valid), 0);
    chk("initdrop_err", int'(frame_err), 0);
    init_v = 1'b1;

    // reset during STREAM
    step(1'b1);
    wait_stream(1);
    rst_v = 1'b1;
    step(1'b0); step(1'b0);
    chk_all_zero("midrst");
    rst_v = 1'b0;
    step(1'b0);

    // randomized frames
    i = frames_done;
    for (int k = 0; k < 4; k++) begin
      rdy_mode = 2; cap = $urandom_range(PF, 40);
      step(1'b1);
      run_idle(400);
    end
    chk("random_frames", frames_done - i, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_rd_stream.md
SDRAM_RD_STREAM -- requirements
Module: sdram_rd_stream

Interface
REQ-001 Parameter H_PIX, default 640: pixels per line.
REQ-002 Parameter V_LINES, default 480: lines per frame.
REQ-003 Parameter RST_CYC, default 8: rd_rst pulse length in cycles.
REQ-004 Parameter PREFILL, default 16: rd_fifo_num level required before streaming starts.
REQ-005 sys_clk  in  1  sole clock; also the read FIFO read clock.
REQ-006 sys_rst  in  1  reset, synchronous, active-high.
REQ-007 init_end  in  1  SDRAM initialisation done.
REQ-008 frame_start  in  1  single-cycle request to stream one frame.
REQ-009 rd_fifo_num  in  10  read FIFO fill level.
REQ-010 rd_fifo_rd_data  in  16  read FIFO data, valid one cycle after rd_fifo_rd_req.
REQ-011 rd_fifo_rd_req  out  1  read FIFO pop.
REQ-012 rd_rst  out  1  read-side clear toward the SDRAM FIFO controller.
REQ-013 read_valid  out  1  SDRAM read enable toward the FIFO controller.
REQ-014 m_valid / m_ready  out / in  1 / 1  pixel stream handshake.
REQ-015 m_data  out  16  pixel.
REQ-016 m_sof  out  1  high with the first pixel of a frame.
REQ-017 m_eol  out  1  high with the last pixel of each line.
REQ-018 frame_err  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-019 The block SHALL implement the states IDLE, FLUSH, FILL, STREAM and SHALL move between them only on rising sys_clk.
REQ-020 IDLE: on frame_start=1 with init_end=1, the next state SHALL be FLUSH. frame_start with init_end=0 SHALL be ignored.
REQ-021 FLUSH: rd_rst=1 and read_valid=0 for exactly RST_CYC cycles, then FILL. rd_fifo_rd_req=0.
REQ-022 FILL: read_valid=1. When rd_fifo_num >= PREFILL, the next state SHALL be STREAM.
REQ-023 STREAM: read_valid=1. After H_PIX*V_LINES accepted beats, the next state SHALL be IDLE and read_valid SHALL drop to 0.
REQ-024 Output buffer:
- 2-entry buffer.
- rd_fifo_rd_req=1 only in STREAM, when occupancy + reads-in-flight < 2, rd_fifo_num > reads-in-flight, and pops issued < H_PIX*V_LINES.
REQ-025 m_valid SHALL equal buffer non-empty; m_data is the buffer head.
REQ-026 A beat is accepted when m_valid=1 and m_ready=1. m_valid and m_data SHALL hold while m_ready=0.
REQ-027 A simultaneous accept and FIFO-data arrival SHALL keep occupancy unchanged with order preserved. No data SHALL be lost or duplicated.
REQ-028 Pixel counter x_cnt (0..H_PIX-1) and line counter y_cnt (0..V_LINES-1) SHALL advance on accepted beats only. x_cnt wraps to 0 and increments y_cnt.
REQ-029 m_sof = m_valid and x_cnt==0 and y_cnt==0. m_eol = m_valid and x_cnt==H_PIX-1.
REQ-030 frame_start in FLUSH, FILL or STREAM SHALL:
- pulse frame_err for one cycle;
- clear buffer, in-flight count and counters;
- enter FLUSH (restart).
Data returning from an already-issued read SHALL be discarded.
REQ-031 init_end falling in any state other than IDLE SHALL force IDLE next cycle, with no frame_err.
REQ-032 A full frame SHALL pop exactly H_PIX*V_LINES FIFO words.

Reset
REQ-033 While sys_rst=1, the block SHALL enter IDLE. Outputs: rd_fifo_rd_req=0, rd_rst=0, read_valid=0, m_valid=0, m_data=0, m_sof=0, m_eol=0, frame_err=0. Buffer, in-flight count and counters are cleared.
REQ-034 Reset asserted mid-frame SHALL take effect on the next edge. A read issued the cycle before reset SHALL NOT be captured.

Verification
REQ-035 H_PIX=4, V_LINES=2, init_end=1, frame_start pulse, m_ready=1, FIFO preloaded with 0x0001..0x0008 -> rd_rst high 8 cycles; then m_data 0x0001..0x0008 in order; m_sof with 0x0001; m_eol with 0x0004 and 0x0008; exactly 8 pops; back to IDLE.
REQ-036 Same frame with m_ready toggling 1,0,0,1 repeatedly -> identical data sequence; m_data stable while stalled; occupancy never exceeds 2.
REQ-037 rd_fifo_num held at 15 with PREFILL=16 -> block stays in FILL with read_valid=1 and m_valid=0; raising it to 16 -> STREAM next cycle.
REQ-038 frame_start after 3 accepted beats -> frame_err pulse, m_valid=0 next cycle, FLUSH with rd_rst asserted; the restarted frame begins with m_sof.
REQ-039 frame_start with init_end=0 -> state stays IDLE, rd_rst never asserted. sys_rst during STREAM -> all outputs 0 on the next cycle.
